// File: rtl/paralelo_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : paralelo_serial_pkg
// Description : Shared constants and state encoding for the byte-to-serial
//               transmitter (comma character, byte width, FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package paralelo_serial_pkg;

    localparam int BYTE_W = 8;

    // Idle / training character; the receiver locks onto repeated commas.
    localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        TRAIN    = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

endpackage : paralelo_serial_pkg
`default_nettype wire

// File: rtl/paralelo_serial_fifo.sv
`default_nettype none
// ============================================================================
// Module      : paralelo_serial_fifo
// Description : Small synchronous byte FIFO with exact occupancy count.
//               Reads are registered-state only, so a byte written at an
//               edge becomes visible on o_data after that edge (no bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module paralelo_serial_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_32f,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               i_data,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];

    // A full FIFO never accepts, even if the head leaves at the same edge.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_32f) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : paralelo_serial_fifo
`default_nettype wire

// File: rtl/paralelo_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : paralelo_serial_tx
// Description : Byte-to-serial transmitter. Buffers bytes in a FIFO, opens
//               the lane with a comma training burst, then serializes data
//               MSB-first, filling idle byte slots with the comma character.
// Revision    : 1.0 - initial release
// ============================================================================
module paralelo_serial_tx #(
    parameter int         DEPTH       = 4,
    parameter int         TRAIN_BYTES = 6,
    parameter logic [7:0] COMMA       = paralelo_serial_pkg::COMMA
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic [7:0]             data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic                   data_out,
    output logic                   tx_active,
    output logic                   comma_collision,
    output logic [$clog2(DEPTH):0] fifo_level
);

    import paralelo_serial_pkg::*;

    localparam int TRAIN_CNT_W = $clog2(TRAIN_BYTES + 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [7:0]             r_shreg;
    logic [7:0]             w_shreg_next;
    logic [2:0]             r_bit_cnt;
    logic [2:0]             w_bit_cnt_next;
    logic [TRAIN_CNT_W-1:0] r_train_cnt;
    logic [TRAIN_CNT_W-1:0] w_train_cnt_next;
    logic                   r_tx_active;
    logic                   w_tx_active_next;
    logic                   r_comma_collision;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [7:0]             w_fifo_data;
    logic                   w_boundary;
    logic                   w_train_done;

    assign ready_out       = !w_full && (r_state != RST_HOLD);
    assign w_push          = valid_in && ready_out;
    assign w_boundary      = (r_bit_cnt == 3'd7);
    assign w_train_done    = (r_train_cnt == TRAIN_CNT_W'(TRAIN_BYTES));

    assign data_out        = r_shreg[7];
    assign tx_active       = r_tx_active;
    assign comma_collision = r_comma_collision;

    paralelo_serial_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_32f (clk_32f),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (data_in),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // State, shifter, counters and status flags; reset discards everything.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state           <= RST_HOLD;
            r_shreg           <= '0;
            r_bit_cnt         <= '0;
            r_train_cnt       <= '0;
            r_tx_active       <= 1'b0;
            r_comma_collision <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_shreg           <= w_shreg_next;
            r_bit_cnt         <= w_bit_cnt_next;
            r_train_cnt       <= w_train_cnt_next;
            r_tx_active       <= w_tx_active_next;
            r_comma_collision <= w_push && (data_in == COMMA);
        end
    end

    // Next-state: shift every cycle, reload the shifter at each byte boundary.
    always_comb begin
        w_state_next     = r_state;
        w_shreg_next     = {r_shreg[6:0], 1'b0};
        w_bit_cnt_next   = r_bit_cnt + 3'd1;
        w_train_cnt_next = r_train_cnt;
        w_tx_active_next = r_tx_active;
        w_pop            = 1'b0;

        case (r_state)
            RST_HOLD: begin
                w_shreg_next     = COMMA;
                w_bit_cnt_next   = 3'd0;
                w_train_cnt_next = TRAIN_CNT_W'(1);
                w_state_next     = TRAIN;
            end
            TRAIN: begin
                if (w_boundary) begin
                    if (w_train_done) begin
                        // Last training comma done: first slot follows ACTIVE rules.
                        w_state_next     = ACTIVE;
                        w_tx_active_next = 1'b1;
                        if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_shreg_next = w_fifo_data;
                        end else begin
                            w_shreg_next = COMMA;
                        end
                    end else begin
                        w_shreg_next     = COMMA;
                        w_train_cnt_next = r_train_cnt + 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (w_boundary) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shreg_next = w_fifo_data;
                    end else begin
                        w_shreg_next = COMMA;
                    end
                end
            end
            default: begin
                w_state_next = RST_HOLD;
            end
        endcase
    end

endmodule : paralelo_serial_tx
`default_nettype wire
